// File: rtl/nco_sweep_ctrl.sv
// Programmable frequency-sweep (chirp) tuning-word generator for the NCO: sawtooth or triangle between start and stop.
// Optional build macro SWEEP_LOG_EN selects a proportional (log-frequency) step of max(ctrl >> LOG_SHIFT, step).
module nco_sweep_ctrl #(
  parameter int WIDTH     = 32,
  parameter int DWELL_W   = 24,
  parameter int LOG_SHIFT = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [WIDTH-1:0]   start_word,
  input  logic [WIDTH-1:0]   stop_word,
  input  logic [WIDTH-1:0]   step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mode,
  output logic [WIDTH-1:0]   ctrl,
  output logic               sweep_done,
  output logic               busy
);

  if (LOG_SHIFT < 1 || LOG_SHIFT >= WIDTH) begin : g_shift_check
    $error("nco_sweep_ctrl: LOG_SHIFT must lie in 1..WIDTH-1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ENDPT} state_t;

  localparam logic [DWELL_W-1:0] DW_ONE = DWELL_W'(1);

  state_t             state;
  logic [WIDTH-1:0]   start_q;
  logic [WIDTH-1:0]   stop_q;
  logic [WIDTH-1:0]   step_q;
  logic [DWELL_W-1:0] reload_q;
  logic [DWELL_W-1:0] cnt;
  logic               mode_q;
  logic               dir0_q;   // 1 = start->stop climbs (unsigned)
  logic               fwd_q;    // 1 = heading toward stop, 0 = returning toward start

  logic               up;
  logic [WIDTH-1:0]   target;
  logic [WIDTH-1:0]   inc;
  logic [WIDTH:0]     nxt;

  // A dwell of 0 behaves as 1: the counter reload value is max(dwell,1)-1.
  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
    dwell_reload = (d == '0) ? '0 : d - DW_ONE;
  endfunction

  // Returns {hit, word}: one-bit-wider arithmetic catches carry/borrow, and any
  // overshoot of the target (or wrap) saturates the word onto the target.
  function automatic logic [WIDTH:0] step_sat(input logic [WIDTH-1:0] cur,
                                              input logic [WIDTH-1:0] amt,
                                              input logic [WIDTH-1:0] tgt,
                                              input logic             climb);
    logic [WIDTH:0] ext;
    logic           hit;
    if (climb) begin
      ext = {1'b0, cur} + {1'b0, amt};
      hit = ext[WIDTH] || (ext[WIDTH-1:0] >= tgt);
    end else begin
      ext = {1'b0, cur} - {1'b0, amt};
      hit = ext[WIDTH] || (ext[WIDTH-1:0] <= tgt);
    end
    step_sat = hit ? {1'b1, tgt} : {1'b0, ext[WIDTH-1:0]};
  endfunction

  assign up     = fwd_q ? dir0_q : ~dir0_q;
  assign target = fwd_q ? stop_q : start_q;

`ifdef SWEEP_LOG_EN
  logic [WIDTH-1:0] prop;
  assign prop = ctrl >> LOG_SHIFT;
  assign inc  = (prop > step_q) ? prop : step_q;
`else
  assign inc  = step_q;
`endif

  assign nxt = step_sat(ctrl, inc, target, up);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ctrl       <= '0;
      sweep_done <= 1'b0;
      busy       <= 1'b0;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      reload_q   <= '0;
      cnt        <= '0;
      mode_q     <= 1'b0;
      dir0_q     <= 1'b0;
      fwd_q      <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= LOAD;
            busy  <= 1'b1;
          end
          LOAD: begin
            start_q  <= start_word;
            stop_q   <= stop_word;
            step_q   <= step;
            mode_q   <= mode;
            reload_q <= dwell_reload(dwell);
            cnt      <= dwell_reload(dwell);
            dir0_q   <= (stop_word >= start_word);
            fwd_q    <= 1'b1;
            ctrl     <= start_word;
            state    <= RUN;
          end
          RUN: begin
            if (cnt == '0) begin
              cnt  <= reload_q;
              ctrl <= nxt[WIDTH-1:0];
              if (nxt[WIDTH]) begin
                sweep_done <= 1'b1;
                state      <= ENDPT;
              end
            end else begin
              cnt <= cnt - DW_ONE;
            end
          end
          ENDPT: begin
            // Endpoint is held one dwell; triangle then turns around, sawtooth restarts.
            if (cnt == '0) begin
              cnt   <= reload_q;
              state <= RUN;
              if (mode_q) begin
                fwd_q <= ~fwd_q;
              end else begin
                fwd_q <= 1'b1;
                ctrl  <= start_q;
              end
            end else begin
              cnt <= cnt - DW_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: a word-list sweep model fills an expected per-cycle queue,
// and a negedge monitor pops one entry per cycle and compares ctrl / sweep_done / busy.
module tb_nco_sweep_ctrl;

  localparam int    LOG_SHIFT = 6;
  localparam int    MAXN      = 1023;
  localparam longint MAXW     = 64'h0000_0000_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] start_word;
  logic [31:0] stop_word;
  logic [31:0] step;
  logic [23:0] dwell;
  logic        mode;
  logic [31:0] ctrl;
  logic        sweep_done;
  logic        busy;

  nco_sweep_ctrl #(.WIDTH(32), .DWELL_W(24), .LOG_SHIFT(LOG_SHIFT)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .start_word(start_word), .stop_word(stop_word), .step(step),
    .dwell(dwell), .mode(mode),
    .ctrl(ctrl), .sweep_done(sweep_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    bit          d;
    bit          b;
  } samp_t;

  samp_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_ctrl;
  logic [31:0] m_ctrl [0:MAXN];
  bit          m_done [0:MAXN];
  int          cur_n;

  // Monitor: one expected sample per cycle, checked mid-cycle.
  initial begin
    samp_t s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        n_checks++;
        if (ctrl !== s.c || sweep_done !== s.d || busy !== s.b) begin
          n_fail++;
          $display("FAIL sample t=%0t: got ctrl=%h done=%b busy=%b, expected ctrl=%h done=%b busy=%b",
                   $time, ctrl, sweep_done, busy, s.c, s.d, s.b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic push_s(input logic [31:0] c, input bit d, input bit b);
    samp_t s;
    s.c = c; s.d = d; s.b = b;
    exp_q.push_back(s);
  endtask

  task automatic emit(input longint v, input int hold, input bit d, inout int idx, input int n);
    for (int k = 0; k < hold; k++) begin
      if (idx <= n) begin
        m_ctrl[idx] = v[31:0];
        m_done[idx] = d && (k == 0);
        idx++;
      end
    end
  endtask

  // Sweep as a list of words, each shown for one dwell period (a triangle endpoint for two).
  task automatic build_model(input longint s, input longint e, input longint st,
                             input int d, input bit md, input int n);
    longint cur, tgt, inc, nxt;
    bit     fwd, up0, up, hit;
    int     idx, dd;
    dd  = (d == 0) ? 1 : d;
    up0 = (e >= s);
    fwd = 1'b1;
    cur = s;
    idx = 0;
    emit(cur, dd, 1'b0, idx, n);
    while (idx <= n) begin
      tgt = fwd ? e : s;
      up  = fwd ? up0 : !up0;
      inc = st;
`ifdef SWEEP_LOG_EN
      if ((cur >> LOG_SHIFT) > inc) inc = cur >> LOG_SHIFT;
`endif
      nxt = up ? cur + inc : cur - inc;
      hit = up ? (nxt >= tgt) : (nxt <= tgt);
      if (hit) begin
        cur = tgt;
        if (md) begin
          emit(cur, 2 * dd, 1'b1, idx, n);
          fwd = !fwd;
        end else begin
          emit(cur, dd, 1'b1, idx, n);
          cur = s;
          emit(cur, dd, 1'b0, idx, n);
        end
      end else begin
        cur = nxt;
        emit(cur, dd, 1'b0, idx, n);
      end
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge with the queue drained.
  task automatic idle(input int n);
    repeat (n) push_s(last_ctrl, 1'b0, 1'b0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input longint s, input longint e, input longint st,
                           input int d, input bit md, input int n);
    build_model(s, e, st, d, md, n);
    start_word = s[31:0];
    stop_word  = e[31:0];
    step       = st[31:0];
    dwell      = 24'(d);
    mode       = md;
    enable     = 1'b1;
    push_s(last_ctrl, 1'b0, 1'b0);  // still IDLE this cycle
    push_s(last_ctrl, 1'b0, 1'b1);  // LOAD
    for (int j = 0; j < n; j++) push_s(m_ctrl[j], m_done[j], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    // Inputs are latched by now; scrambling them must not disturb the sweep.
    start_word = $urandom;
    stop_word  = $urandom;
    step       = $urandom;
    dwell      = 24'($urandom_range(0, 7));
    mode       = 1'($urandom_range(0, 1));
    repeat (n) @(posedge clk);
    #1;
    cur_n = n;
  endtask

  task automatic stop_sweep();
    enable = 1'b0;
    push_s(m_ctrl[cur_n], m_done[cur_n], 1'b1);
    push_s(m_ctrl[cur_n], 1'b0, 1'b0);
    last_ctrl = m_ctrl[cur_n];
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_mid();
    #2;
    rst    = 1'b1;
    enable = 1'b0;
    push_s(32'h0, 1'b0, 1'b0);  // sampled before any further clock edge
    #1;
    n_checks++;
    if (ctrl !== 32'h0 || busy !== 1'b0 || sweep_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset t=%0t: got ctrl=%h done=%b busy=%b, expected all zero",
               $time, ctrl, sweep_done, busy);
    end
    @(posedge clk);
    #1;
    push_s(32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    last_ctrl = 32'h0;
  endtask

  initial begin
    longint s, e, st;
    int     sel, d, n;
    bit     md;
    rst        = 1'b1;
    enable     = 1'b0;
    start_word = '0;
    stop_word  = '0;
    step       = '0;
    dwell      = '0;
    mode       = 1'b0;
    last_ctrl  = 32'h0;
    cur_n      = 0;
    @(posedge clk);
    #1;
    push_s(32'h0, 1'b0, 1'b0);
    push_s(32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    run_sweep(1000, 1040, 10, 4, 1'b0, 60);
    stop_sweep();
    idle(2);
    run_sweep(1000, 1040, 10, 4, 1'b1, 90);
    stop_sweep();
    idle(2);

    run_sweep(64'hFFFF_FFF0, 64'hFFFF_FFFF, 64'h20, 1, 1'b0, 12);
    stop_sweep();
    run_sweep(64'h10, 0, 64'h20, 1, 1'b0, 12);
    stop_sweep();
    idle(1);

    run_sweep(500, 900, 25, 2, 1'b1, 40);
    stop_sweep();
    idle(3);
    run_sweep(7000, 6000, 100, 3, 1'b0, 50);
    reset_mid();

    run_sweep(64'h1234, 64'h5678, 0, 0, 1'b0, 30);
    stop_sweep();
    run_sweep(64'h42, 64'h42, 5, 3, 1'b1, 30);
    stop_sweep();
    run_sweep(64'h42, 64'h42, 5, 0, 1'b0, 12);
    stop_sweep();
    idle(1);

`ifdef SWEEP_LOG_EN
    run_sweep(64'h1000, 64'h2000, 1, 1, 1'b0, 70);
    stop_sweep();
    idle(1);
`endif

    for (int it = 0; it < 12; it++) begin
      s   = longint'($urandom);
      sel = $urandom_range(0, 3);
      st  = ($urandom_range(0, 4) == 0) ? 0 : longint'($urandom_range(1, 80));
      case (sel)
        0: begin
          e = s + longint'($urandom_range(0, 300));
          if (e > MAXW) e = MAXW;
        end
        1: begin
          e = s - longint'($urandom_range(0, 300));
          if (e < 0) e = 0;
        end
        2: begin
          e  = longint'($urandom);
          st = longint'($urandom >> $urandom_range(0, 4));
        end
        default: e = s;
      endcase
      d  = $urandom_range(0, 5);
      md = 1'($urandom_range(0, 1));
      n  = $urandom_range(20, 150);
      run_sweep(s, e, st, d, md, n);
      if ($urandom_range(0, 2) == 0) reset_mid();
      else stop_sweep();
      idle($urandom_range(1, 3));
    end

    if (n_checks == 0) begin
      n_fail++;
      $display("FAIL no samples were checked");
    end
    if (n_fail != 0) $display("FAIL %0d mismatches detected", n_fail);
    else $display("PASS all samples matched");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
